// File: rtl/sram_bus_dualport_arbiter.sv
// Two-master arbiter for a dual-port SRAM-bus RAM: reads on port A, writes on port B, round-robin per port.
// Optional ARB_PERF_CNT_EN adds saturating contention/blocking counters.
module sram_bus_dualport_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [MW-1:0] m0_wem,
  output logic          m0_addr_ok,
  output logic          m0_data_ok,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [MW-1:0] m1_wem,
  output logic          m1_addr_ok,
  output logic          m1_data_ok,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_req_a,
  output logic [AW-1:0] ram_addr_a,
  input  logic          ram_addr_ok_a,
  input  logic          ram_data_ok_a,
  input  logic [DW-1:0] ram_dout_a,
  output logic          ram_req_b,
  output logic          ram_we_b,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_din_b,
  output logic [MW-1:0] ram_wem_b,
  input  logic          ram_addr_ok_b,
  input  logic          ram_data_ok_b
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_contend_cnt,
  output logic [31:0]   perf_block_cnt
`endif
);

  logic rd_req0, rd_req1, wr_req0, wr_req1;
  logic rd_any, wr_any, rd_both, wr_both;
  logic rd_sel, wr_sel;
  logic rd_acc, wr_acc;
  logic rr_rd, rr_wr;
  logic rd_owner, wr_owner, rd_vld, wr_vld;

  // Requests are masked while reset is held so every output reads 0 during reset.
  always_comb begin
    rd_req0 = rst_n & m0_req & ~m0_we;
    rd_req1 = rst_n & m1_req & ~m1_we;
    wr_req0 = rst_n & m0_req & m0_we;
    wr_req1 = rst_n & m1_req & m1_we;
    rd_any  = rd_req0 | rd_req1;
    wr_any  = wr_req0 | wr_req1;
    rd_both = rd_req0 & rd_req1;
    wr_both = wr_req0 & wr_req1;
    rd_sel  = rd_both ? rr_rd : rd_req1;
    wr_sel  = wr_both ? rr_wr : wr_req1;
    rd_acc  = rd_any & ram_addr_ok_a;
    wr_acc  = wr_any & ram_addr_ok_b;
  end

  always_comb begin
    ram_req_a  = rd_any;
    ram_addr_a = rd_any ? (rd_sel ? m1_addr : m0_addr) : '0;
    ram_req_b  = wr_any;
    ram_we_b   = wr_any;
    ram_addr_b = wr_any ? (wr_sel ? m1_addr  : m0_addr)  : '0;
    ram_din_b  = wr_any ? (wr_sel ? m1_wdata : m0_wdata) : '0;
    ram_wem_b  = wr_any ? (wr_sel ? m1_wem   : m0_wem)   : '0;
  end

  always_comb begin
    m0_addr_ok = (rd_acc & ~rd_sel) | (wr_acc & ~wr_sel);
    m1_addr_ok = (rd_acc &  rd_sel) | (wr_acc &  wr_sel);
    m0_data_ok = (ram_data_ok_a & rd_vld & ~rd_owner) | (ram_data_ok_b & wr_vld & ~wr_owner);
    m1_data_ok = (ram_data_ok_a & rd_vld &  rd_owner) | (ram_data_ok_b & wr_vld &  wr_owner);
    m0_rdata   = (rd_vld & ~rd_owner) ? ram_dout_a : '0;
    m1_rdata   = (rd_vld &  rd_owner) ? ram_dout_a : '0;
  end

  // Owner flags live exactly one cycle: the RAM answers one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_rd    <= 1'b0;
      rr_wr    <= 1'b0;
      rd_owner <= 1'b0;
      wr_owner <= 1'b0;
      rd_vld   <= 1'b0;
      wr_vld   <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      wr_vld <= wr_acc;
      if (rd_acc) rd_owner <= rd_sel;
      if (wr_acc) wr_owner <= wr_sel;
      if (rd_acc & rd_both) rr_rd <= ~rd_sel;
      if (wr_acc & wr_both) rr_wr <= ~wr_sel;
    end
  end

`ifdef ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_contend_cnt <= '0;
      perf_block_cnt   <= '0;
    end else begin
      if (rd_both | wr_both)        perf_contend_cnt <= sat_inc(perf_contend_cnt);
      if (rd_any & ~ram_addr_ok_a)  perf_block_cnt   <= sat_inc(perf_block_cnt);
    end
  end
`endif

endmodule
